// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the DMEM bridge
package dmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RMW_RD,
        RMW_WR,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_t;

    // Bit 31 is the LSB; clearing bits 30:31 gives the word address.
    localparam logic [0:31] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - big-endian lane extraction and sub-word store merge
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [0:31] word,
    input  logic [0:1]  offset,
    input  logic [1:0]  size,
    input  logic        sign_extend,
    input  logic [0:31] new_data,
    output logic [0:31] load_data,
    output logic [0:31] merged
);

    logic [0:7]  byte_lane;
    logic [0:15] half_lane;

    // Lane 0 holds the most significant byte of the word.
    always_comb begin
        byte_lane = word[0:7];
        case (offset)
            2'd0: byte_lane = word[0:7];
            2'd1: byte_lane = word[8:15];
            2'd2: byte_lane = word[16:23];
            2'd3: byte_lane = word[24:31];
            default: byte_lane = word[0:7];
        endcase
        half_lane = offset[0] ? word[16:31] : word[0:15];
    end

    always_comb begin
        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{24{sign_extend & byte_lane[0]}}, byte_lane};
            SZ_HALF: load_data = {{16{sign_extend & half_lane[0]}}, half_lane};
            default: load_data = word;
        endcase
    end

    // Store data arrives right-justified, so its low lane is what gets placed.
    always_comb begin
        merged = word;
        if (size == SZ_BYTE) begin
            case (offset)
                2'd0: merged[0:7]   = new_data[24:31];
                2'd1: merged[8:15]  = new_data[24:31];
                2'd2: merged[16:23] = new_data[24:31];
                2'd3: merged[24:31] = new_data[24:31];
                default: merged = word;
            endcase
        end else if (size == SZ_HALF) begin
            if (offset[0]) begin
                merged[16:31] = new_data[16:31];
            end else begin
                merged[0:15] = new_data[16:31];
            end
        end else begin
            merged = new_data;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - MEM-stage DMEM port to req/ack external memory bridge
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int WAIT_LIMIT  = 255,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:31] addr_from_proc,
    input  logic [0:31] data_from_proc,
    input  logic        read_from_proc,
    input  logic        write_enable_from_proc,
    input  logic        byte_from_proc,
    input  logic        half_word_from_proc,
    input  logic        sign_extend_from_proc,
    output logic [0:31] data_to_proc,
    output logic        stall,
    output logic        misalign,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [0:31] mem_addr,
    output logic [0:31] mem_wdata,
    input  logic [0:31] mem_rdata,
    input  logic        mem_ack
);

    localparam int               CNT_W     = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

    state_t           state;
    state_t           state_next;
    access_size_t     size_in;
    access_size_t     size_q;
    logic [0:1]       offset_q;
    logic             sign_q;
    logic             store_q;
    logic [0:31]      store_data_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             req;
    logic             is_store;
    logic             misaligned;
    logic             ack;
    logic             waiting;
    logic             timeout;
    logic [0:31]      load_word;
    logic [0:31]      merged_word;

    assign req      = read_from_proc | write_enable_from_proc;
    assign is_store = write_enable_from_proc;
    assign stall    = req && (state != DONE);

    always_comb begin
        size_in = SZ_WORD;
        if (byte_from_proc) begin
            size_in = SZ_BYTE;
        end else if (half_word_from_proc) begin
            size_in = SZ_HALF;
        end
    end

    assign misaligned = CHECK_ALIGN &&
                        (((size_in == SZ_HALF) && addr_from_proc[31]) ||
                         ((size_in == SZ_WORD) && (addr_from_proc[30:31] != 2'b00)));

    // An ack only counts while a request is on the bus; the first RMW_WR cycle is the bus gap.
    assign ack     = mem_ack && mem_req;
    assign waiting = (state == ACCESS) || (state == RMW_RD) || ((state == RMW_WR) && mem_req);
    assign cnt_inc = wait_cnt + CNT_W'(1);
    assign timeout = waiting && !ack && (cnt_inc == CNT_LIMIT);

    dmem_lane_align u_lane (
        .word        (mem_rdata),
        .offset      (offset_q),
        .size        (size_q),
        .sign_extend (sign_q),
        .new_data    (store_data_q),
        .load_data   (load_word),
        .merged      (merged_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        state_next = DONE;
                    end else if (is_store && (size_in != SZ_WORD)) begin
                        state_next = RMW_RD;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS, RMW_WR: begin
                if (ack || timeout) begin
                    state_next = DONE;
                end
            end
            RMW_RD: begin
                if (ack) begin
                    state_next = RMW_WR;
                end else if (timeout) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            data_to_proc <= '0;
            misalign     <= 1'b0;
            bus_error    <= 1'b0;
            wait_cnt     <= '0;
            size_q       <= SZ_WORD;
            offset_q     <= 2'b00;
            sign_q       <= 1'b0;
            store_q      <= 1'b0;
            store_data_q <= '0;
        end else begin
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        size_q       <= size_in;
                        offset_q     <= addr_from_proc[30:31];
                        sign_q       <= sign_extend_from_proc;
                        store_q      <= is_store;
                        store_data_q <= data_from_proc;
                        wait_cnt     <= '0;
                        if (misaligned) begin
                            misalign     <= 1'b1;
                            data_to_proc <= '0;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= is_store && (size_in == SZ_WORD);
                            mem_addr <= addr_from_proc & WORD_MASK;
                            if (is_store) begin
                                mem_wdata <= data_from_proc;
                            end
                        end
                    end
                end
                ACCESS, RMW_RD, RMW_WR: begin
                    if (!mem_req) begin
                        // Gap cycle after the RMW read; relaunch as the write phase.
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        wait_cnt <= '0;
                    end else if (ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wait_cnt <= '0;
                        if ((state == ACCESS) && !store_q) begin
                            data_to_proc <= load_word;
                        end
                        if (state == RMW_RD) begin
                            mem_wdata <= merged_word;
                        end
                    end else if (timeout) begin
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        bus_error    <= 1'b1;
                        data_to_proc <= '0;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the processor's MEM-stage DMEM port. It turns single-cycle load/store requests into word-wide transactions on a multi-cycle external memory that uses a req/ack handshake.
- Performs big-endian byte and halfword lane selection, sign extension, and read-modify-write for sub-word stores.
- Drives the pipeline-wide stall while a transaction is outstanding.

Parameters:
- WAIT_LIMIT, 255: maximum cycles to wait for mem_ack before aborting with a bus error.
- CHECK_ALIGN, 1: if 1, misaligned accesses are trapped; if 0, the low address bits are ignored for halfword and word accesses.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- addr_from_proc  in  [0:31]  byte address (bit 31 = LSB)
- data_from_proc  in  [0:31]  store data, right-justified for byte/halfword
- read_from_proc  in  1  load request (mem_to_reg)
- write_enable_from_proc  in  1  store request
- byte_from_proc  in  1  byte access
- half_word_from_proc  in  1  halfword access
- sign_extend_from_proc  in  1  sign-extend load result
- data_to_proc  out  [0:31]  formatted load data
- stall  out  1  freeze all pipeline registers
- misalign  out  1  one-cycle pulse on a trapped misaligned access
- bus_error  out  1  sticky until reset; set on timeout
- mem_req  out  1  external request
- mem_we  out  1  external write
- mem_addr  out  [0:31]  word address, low two bits forced to 0
- mem_wdata  out  [0:31]  external write data
- mem_rdata  in  [0:31]  external read data
- mem_ack  in  1  one-cycle completion pulse, valid only while mem_req=1

Behaviour:
- Reset values: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; data_to_proc=0; misalign=0; bus_error=0; wait counter=0.
- Request present (req): read_from_proc | write_enable_from_proc. If both are set, the access is a store.
- Access size: byte_from_proc has priority over half_word_from_proc; neither set means word.
- stall is combinational: stall = req & (state != DONE). It is therefore 1 in the same cycle a request appears in IDLE.
- Lane numbering is big-endian:
  - byte offset o = addr[30:31]; byte lane = bits [8o : 8o+7];
  - halfword lane h = addr[30]; halfword = bits [16h : 16h+15].
- States:
  - IDLE. Misaligned access (CHECK_ALIGN=1: halfword with addr[31]=1, or word with addr[30:31]!=0) -> DONE, with misalign pulse, data 0, no memory access. Load, or word store -> ACCESS. Sub-word store -> RMW_RD. No request -> stay.
  - ACCESS: mem_req=1; mem_we=1 for a store. On mem_ack -> DONE; for a load, the extracted, extended mem_rdata is latched into data_to_proc.
  - RMW_RD: mem_req=1, mem_we=0. On mem_ack, the store lane is merged into mem_rdata and latched into mem_wdata -> RMW_WR.
  - RMW_WR: mem_req=1, mem_we=1. On mem_ack -> DONE.
  - DONE: stall=0 and data_to_proc is stable. Unconditionally -> IDLE on the next edge (the pipeline advances on that same edge).
- Handshake:
  - mem_req drops in the cycle after the accepted ack.
  - Between the RMW_RD and RMW_WR phases, mem_req is deasserted for exactly one cycle.
  - mem_addr and mem_wdata are held constant while mem_req=1.
- Latency: a load or word store with an ack N cycles after req rises gives stall high for N+1 cycles. A sub-word store costs the sum of both phases plus one cycle.
- Timeout:
  - The wait counter resets on entry to each wait state and increments every cycle without an ack.
  - When it reaches WAIT_LIMIT: drop mem_req, set bus_error, go to DONE with data_to_proc=0; a store does not complete.
  - An ack arriving in the same cycle as the limit wins; no error is raised.
- A stray mem_ack while in IDLE or DONE is ignored.
- Reset mid-transaction: the next state is IDLE with mem_req=0; the aborted store is not retried.
- Sign extension: sign_extend=1 replicates the lane MSB (bit 0 of the byte or halfword) across the upper bits; otherwise the result is zero-filled. For word loads, sign_extend is ignored.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, ACCESS, RMW_RD, RMW_WR, DONE};
  - size enum {SZ_BYTE, SZ_HALF, SZ_WORD};
  - the WORD_MASK constant.
- One combinational sub-module, dmem_lane_align, takes word, offset, size and sign_extend and provides:
  - load extraction;
  - store merge of new data into the old word.
- The top level holds the FSM, wait counter, registers and handshake.

Test Plan:
- Word load, addr=0x100, mem_rdata=0xDEADBEEF, ack 3 cycles after req -> mem_addr=0x100, stall high 4 cycles, data_to_proc=0xDEADBEEF in DONE.
- Signed byte load, addr=0x103, rdata=0x123456F0 -> data_to_proc=0xFFFFFFF0. Repeat with sign_extend=0 -> 0x000000F0. Signed halfword load at 0x100 -> 0x00001234.
- Byte store, addr=0x101, data=0x000000AB, RMW read returns 0x11223344 -> second transaction has mem_we=1, mem_wdata=0x11AB3344, with one idle cycle between the two requests.
- Misaligned word load at 0x102 -> misalign pulses once, no mem_req, stall high 1 cycle, data_to_proc=0. With CHECK_ALIGN=0 -> mem_addr=0x100, normal load.
- Timeout with WAIT_LIMIT=4 and no ack -> mem_req drops after 4 wait cycles, bus_error=1 and stays set across later good accesses until reset.
- Reset asserted during the RMW_WR wait -> mem_req=0 on the next cycle, state IDLE, and a late ack causes no write and no state change.
